// File: rtl/core_logic_if.sv
// core_logic_if: TAP-side strobes and core-side data bundle for the core_logic data register
interface core_logic_if #(
    parameter int DEFAULT = 32
);
    localparam int CW = $clog2(DEFAULT + 1);
    logic                sel;
    logic                capture;
    logic                shift;
    logic                update;
    logic                tdi;
    logic                tdo;
    logic [DEFAULT-1:0]  core_in;
    logic [DEFAULT-1:0]  core_out;
    logic                update_pulse;
    logic                update_err;
    logic [CW-1:0]       shift_count;
    modport master (
        output sel, capture, shift, update, tdi, core_in,
        input  tdo, core_out, update_pulse, update_err, shift_count
    );
    modport slave (
        input  sel, capture, shift, update, tdi, core_in,
        output tdo, core_out, update_pulse, update_err, shift_count
    );
endinterface

// File: rtl/core_logic.sv
// core_logic: core-clocked capture/shift/update test data register behind the TAP
module core_logic #(
    parameter int                 DEFAULT     = 32,
    parameter logic [DEFAULT-1:0] RESET_VALUE = '0
) (
    input logic         clk,
    input logic         rst,
    core_logic_if.slave bus
);
    localparam int CW = $clog2(DEFAULT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEFAULT);
    logic [DEFAULT-1:0] sr;
    logic [DEFAULT-1:0] out_q;
    logic [CW-1:0]      cnt;
    logic               pulse_q;
    logic               err_q;
    assign bus.tdo          = sr[0];
    assign bus.core_out     = out_q;
    assign bus.shift_count  = cnt;
    assign bus.update_pulse = pulse_q;
    assign bus.update_err   = err_q;
    // One action per selected cycle: capture over shift over update; pulses last one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= RESET_VALUE;
            out_q   <= RESET_VALUE;
            cnt     <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
            if (bus.sel) begin
                if (bus.capture) begin
                    sr  <= bus.core_in;
                    cnt <= '0;
                end else if (bus.shift) begin
                    sr  <= {bus.tdi, sr[DEFAULT-1:1]};
                    cnt <= (cnt == FULL) ? cnt : cnt + CW'(1);
                end else if (bus.update) begin
                    if (cnt == FULL) begin
                        out_q   <= sr;
                        pulse_q <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_core_logic.sv
// tb_core_logic: directed self-checking bench for the core_logic data register
module tb_core_logic;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    logic [31:0] w;
    logic [63:0] w64;

    always #5 clk = ~clk;

    core_logic_if #(.DEFAULT(32)) bus ();

    core_logic #(.DEFAULT(32), .RESET_VALUE(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        bus.capture = 1'b0;
        bus.shift   = 1'b0;
        bus.update  = 1'b0;
    endtask

    initial begin
        bus.sel = 1'b0;
        bus.tdi = 1'b0;
        bus.core_in = '0;
        idle();
        tick();
        tick();
        chk("rst_core_out", bus.core_out, 32'h0);
        chk("rst_count", 32'(bus.shift_count), 32'd0);
        chk("rst_tdo", 32'(bus.tdo), 32'd0);
        chk("rst_pulse", 32'(bus.update_pulse), 32'd0);
        chk("rst_err", 32'(bus.update_err), 32'd0);
        rst = 1'b0;
        bus.sel = 1'b1;

        w = 32'hA5A5_0F0F;
        w64 = {32'h0, w};
        bus.core_in = w;
        bus.capture = 1'b1;
        tick();
        idle();
        chk("cap_tdo", 32'(bus.tdo), 32'd1);
        chk("cap_count", 32'(bus.shift_count), 32'd0);
        bus.shift = 1'b1;
        bus.tdi = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("shift_tdo_%0d", k), 32'(bus.tdo), 32'(w64[k]));
        end
        chk("shift_count_full", 32'(bus.shift_count), 32'd32);
        tick();
        chk("shift_count_sat", 32'(bus.shift_count), 32'd32);
        idle();

        w = 32'hDEAD_BEEF;
        bus.capture = 1'b1;
        tick();
        idle();
        bus.shift = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.tdi = w[i];
            tick();
        end
        idle();
        bus.update = 1'b1;
        tick();
        idle();
        chk("full_core_out", bus.core_out, 32'hDEAD_BEEF);
        chk("full_pulse", 32'(bus.update_pulse), 32'd1);
        chk("full_err", 32'(bus.update_err), 32'd0);
        chk("full_count", 32'(bus.shift_count), 32'd0);
        tick();
        chk("full_pulse_drop", 32'(bus.update_pulse), 32'd0);

        bus.capture = 1'b1;
        tick();
        idle();
        bus.shift = 1'b1;
        bus.tdi = 1'b1;
        for (int i = 0; i < 31; i++) tick();
        idle();
        bus.update = 1'b1;
        tick();
        chk("short_err", 32'(bus.update_err), 32'd1);
        chk("short_pulse", 32'(bus.update_pulse), 32'd0);
        chk("short_core_out", bus.core_out, 32'hDEAD_BEEF);
        chk("short_count", 32'(bus.shift_count), 32'd31);
        tick();
        idle();
        chk("short_err_again", 32'(bus.update_err), 32'd1);
        tick();
        chk("short_err_drop", 32'(bus.update_err), 32'd0);

        bus.core_in = 32'h0000_0002;
        bus.capture = 1'b1;
        tick();
        idle();
        bus.shift = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("prio_pre_count", 32'(bus.shift_count), 32'd5);
        bus.capture = 1'b1;
        tick();
        idle();
        chk("prio_count", 32'(bus.shift_count), 32'd0);
        chk("prio_tdo", 32'(bus.tdo), 32'd0);

        bus.core_in = 32'h0000_0001;
        bus.capture = 1'b1;
        tick();
        idle();
        bus.sel = 1'b0;
        bus.shift = 1'b1;
        bus.tdi = 1'b0;
        tick();
        chk("nosel_tdo", 32'(bus.tdo), 32'd1);
        chk("nosel_count", 32'(bus.shift_count), 32'd0);
        idle();
        bus.update = 1'b1;
        tick();
        idle();
        chk("nosel_err", 32'(bus.update_err), 32'd0);
        chk("nosel_core_out", bus.core_out, 32'hDEAD_BEEF);
        bus.sel = 1'b1;

        bus.core_in = 32'hFFFF_FFFF;
        bus.capture = 1'b1;
        tick();
        idle();
        bus.shift = 1'b1;
        bus.tdi = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        idle();
        chk("mid_count", 32'(bus.shift_count), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 32'(bus.shift_count), 32'd0);
        chk("mid_rst_tdo", 32'(bus.tdo), 32'd0);
        chk("mid_rst_core_out", bus.core_out, 32'h0);
        bus.update = 1'b1;
        tick();
        idle();
        chk("mid_rst_err", 32'(bus.update_err), 32'd1);
        chk("mid_rst_pulse", 32'(bus.update_pulse), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
